// File: rtl/pcpu_mio_model.sv
// pcpu_mio_model: imem/dmem responder with MIO_ready wait states for PCPU benches.
// Optional MIO_ERR_EN adds a sticky err output for bad accesses.
module pcpu_mio_model #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256,
   parameter int WAIT_CYCLES = 0,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_data,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              MIO_ready,
   input  logic              load_we,
   input  logic              load_sel,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data
`ifdef MIO_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   logic [DATA_W-1:0] imem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic rdy;
   logic complete;
   logic rd_done;
   logic wr_done;

   logic [IW-1:0] i_idx;
   logic [IW-1:0] li_idx;
   logic [DW-1:0] d_idx;
   logic [DW-1:0] ld_idx;
   logic i_oor;
   logic li_oor;
   logic d_oor;
   logic ld_oor;
   logic unused_bits;

   assign i_idx  = inst_addr[IW+1:2];
   assign li_idx = load_addr[IW+1:2];
   assign d_idx  = mem_addr[DW+1:2];
   assign ld_idx = load_addr[DW+1:2];
   assign i_oor  = |(inst_addr >> (IW + 2));
   assign li_oor = |(load_addr >> (IW + 2));
   assign d_oor  = |(mem_addr >> (DW + 2));
   assign ld_oor = |(load_addr >> (DW + 2));

   assign unused_bits = ^{inst_addr[1:0], load_addr[1:0], mem_addr[1:0]};

   assign inst_data = i_oor ? NOP_WORD : imem[i_idx];

   // Reset forces the bus idle regardless of what the held CPU drives.
   assign MIO_ready = rdy | ~rst;
   assign complete  = rdy & mem_req & rst;
   assign rd_done   = complete & ~mem_we;
   assign wr_done   = complete & mem_we & ~d_oor;

   assign mem_data_in = (rd_done && !d_oor) ? dmem[d_idx] : '0;

   // Instruction memory: written only by the preload port.
   always_ff @(posedge clk) begin
      if (load_we && !load_sel && !li_oor)
         imem[li_idx] <= load_data;
   end

   // Data memory: CPU write first so a same-edge preload overrides it.
   always_ff @(posedge clk) begin
      if (wr_done)
         dmem[d_idx] <= mem_data;
      if (load_we && load_sel && !ld_oor)
         dmem[ld_idx] <= load_data;
   end

   // Handshake state and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: IDLE counts as the first low cycle, so WAIT lasts W-1 cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rdy       = 1'b0;
      case (state)
         S_IDLE: begin
            if (WAIT_CYCLES == 0) begin
               rdy = 1'b1;
            end else if (mem_req) begin
               cnt_nxt   = WC - 4'd1;
               state_nxt = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
            end else begin
               rdy = 1'b1;
            end
         end
         S_WAIT: begin
            if (!mem_req) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt_nxt == 4'd0)
                  state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            rdy       = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

`ifdef MIO_ERR_EN
   // Sticky error: misaligned or out-of-range access, or bad fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if ((complete && (d_oor || mem_addr[1:0] != 2'b00)) || i_oor)
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_pcpu_mio_model.sv
// tb_pcpu_mio_model: directed vectors for three wait-state configurations.
// Instance 0: W=0, instance 1: W=3, instance 2: W=2.
module tb_pcpu_mio_model;

   logic clk;
   logic        rstn [3];
   logic [31:0] ia   [3];
   logic [31:0] id   [3];
   logic        req  [3];
   logic        we   [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [31:0] rd   [3];
   logic        rdy  [3];
   logic        lwe  [3];
   logic        lsel [3];
   logic [31:0] la   [3];
   logic [31:0] ld   [3];
`ifdef MIO_ERR_EN
   logic        er   [3];
`endif

   int nvec = 0;
   int nfail = 0;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] iaddr;
      logic        lwe;
      logic [31:0] laddr;
      logic [31:0] ldata;
      logic        rdy;
      logic [31:0] rdata;
      logic [31:0] inst;
   } vec_t;

   vec_t tab [11];

   pcpu_mio_model #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rstn[0]),
      .inst_addr(ia[0]), .inst_data(id[0]),
      .mem_req(req[0]), .mem_we(we[0]),
      .mem_addr(addr[0]), .mem_data(wd[0]),
      .mem_data_in(rd[0]), .MIO_ready(rdy[0]),
      .load_we(lwe[0]), .load_sel(lsel[0]),
      .load_addr(la[0]), .load_data(ld[0])
`ifdef MIO_ERR_EN
      , .err(er[0])
`endif
   );

   pcpu_mio_model #(.WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rstn[1]),
      .inst_addr(ia[1]), .inst_data(id[1]),
      .mem_req(req[1]), .mem_we(we[1]),
      .mem_addr(addr[1]), .mem_data(wd[1]),
      .mem_data_in(rd[1]), .MIO_ready(rdy[1]),
      .load_we(lwe[1]), .load_sel(lsel[1]),
      .load_addr(la[1]), .load_data(ld[1])
`ifdef MIO_ERR_EN
      , .err(er[1])
`endif
   );

   pcpu_mio_model #(.WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst(rstn[2]),
      .inst_addr(ia[2]), .inst_data(id[2]),
      .mem_req(req[2]), .mem_we(we[2]),
      .mem_addr(addr[2]), .mem_data(wd[2]),
      .mem_data_in(rd[2]), .MIO_ready(rdy[2]),
      .load_we(lwe[2]), .load_sel(lsel[2]),
      .load_addr(la[2]), .load_data(ld[2])
`ifdef MIO_ERR_EN
      , .err(er[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic load(input int d, input logic sel,
                       input logic [31:0] a, input logic [31:0] dat);
      @(negedge clk);
      lwe[d] = 1'b1;
      lsel[d] = sel;
      la[d] = a;
      ld[d] = dat;
      @(negedge clk);
      lwe[d] = 1'b0;
   endtask

   task automatic acc(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] dat, input int elat,
                      input logic [31:0] exp, input string nm);
      int lat;
      bit done;
      lat = 0;
      done = 0;
      @(negedge clk);
      req[d] = 1'b1;
      we[d] = w;
      addr[d] = a;
      wd[d] = dat;
      for (int k = 0; k < 12 && !done; k++) begin
         #2;
         if (rdy[d]) begin
            done = 1;
         end else begin
            chk({nm, "_early_data"}, rd[d], 32'h0);
            lat++;
            @(negedge clk);
         end
      end
      if (!done) begin
         nvec++;
         nfail++;
         $display("FAIL %s_timeout: got no ready want ready", nm);
      end else begin
         chk({nm, "_lat"}, 32'(lat), 32'(elat));
         if (!w)
            chk({nm, "_data"}, rd[d], exp);
      end
      @(negedge clk);
      req[d] = 1'b0;
      we[d] = 1'b0;
   endtask

   initial begin
      tab[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h2000_0001};
      tab[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,         32'h400,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h0};
      tab[2]  = '{1'b1, 1'b1, 32'h4,   32'h5A5A_5A5A, 32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h2000_0001};
      tab[3]  = '{1'b1, 1'b0, 32'h4,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h5A5A_5A5A, 32'h2000_0001};
      tab[4]  = '{1'b0, 1'b0, 32'h4,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h2000_0001};
      tab[5]  = '{1'b1, 1'b0, 32'h400, 32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h2000_0001};
      tab[6]  = '{1'b1, 1'b1, 32'h400, 32'hDEAD_BEEF, 32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h0,         32'h2000_0001};
      tab[7]  = '{1'b1, 1'b0, 32'h0,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_1111, 32'h2000_0001};
      tab[8]  = '{1'b1, 1'b0, 32'h6,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h5A5A_5A5A, 32'h2000_0001};
      tab[9]  = '{1'b1, 1'b1, 32'h4,   32'h8888_8888, 32'h8,
                  1'b1, 32'h4, 32'h7777_7777, 1'b1, 32'h0, 32'h2000_0001};
      tab[10] = '{1'b1, 1'b0, 32'h4,   32'h0,         32'h8,
                  1'b0, 32'h0, 32'h0, 1'b1, 32'h7777_7777, 32'h2000_0001};

      for (int d = 0; d < 3; d++) begin
         rstn[d] = 1'b0;
         ia[d] = 32'h8;
         req[d] = 1'b0;
         we[d] = 1'b0;
         addr[d] = '0;
         wd[d] = '0;
         lwe[d] = 1'b0;
         lsel[d] = 1'b0;
         la[d] = '0;
         ld[d] = '0;
      end
      repeat (2) @(negedge clk);

      for (int d = 0; d < 3; d++)
         load(d, 1'b0, 32'h8, 32'h2000_0001);
      load(0, 1'b1, 32'h0, 32'h1111_1111);
      load(1, 1'b1, 32'h8, 32'hCAFE_0008);
      load(1, 1'b1, 32'hC, 32'h1234_5678);
      load(2, 1'b1, 32'h10, 32'hAAAA_0010);

      #2;
      chk("rst_ready_w3", 32'(rdy[1]), 32'h1);
      chk("rst_rdata_w3", rd[1], 32'h0);
      chk("rst_ready_w0", 32'(rdy[0]), 32'h1);
      chk("rst_inst_w3", id[1], 32'h2000_0001);

      @(negedge clk);
      for (int d = 0; d < 3; d++)
         rstn[d] = 1'b1;
`ifdef MIO_ERR_EN
      #2;
      chk("err_after_rst", 32'(er[0]), 32'h0);
`endif

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         req[0] = tab[i].req;
         we[0] = tab[i].we;
         addr[0] = tab[i].addr;
         wd[0] = tab[i].wdata;
         ia[0] = tab[i].iaddr;
         lwe[0] = tab[i].lwe;
         lsel[0] = 1'b1;
         la[0] = tab[i].laddr;
         ld[0] = tab[i].ldata;
         #2;
         chk($sformatf("w0_v%0d_ready", i), 32'(rdy[0]), 32'(tab[i].rdy));
         chk($sformatf("w0_v%0d_rdata", i), rd[0], tab[i].rdata);
         chk($sformatf("w0_v%0d_inst", i), id[0], tab[i].inst);
      end
      @(negedge clk);
      req[0] = 1'b0;
      we[0] = 1'b0;
      lwe[0] = 1'b0;
      ia[0] = 32'h8;

`ifdef MIO_ERR_EN
      #2;
      chk("err_sticky", 32'(er[0]), 32'h1);
      @(negedge clk);
      chk("err_still", 32'(er[0]), 32'h1);
      rstn[0] = 1'b0;
      #1;
      chk("err_cleared", 32'(er[0]), 32'h0);
      @(negedge clk);
      rstn[0] = 1'b1;
`endif

      acc(1, 1'b0, 32'hC, 32'h0, 3, 32'h1234_5678, "w3_rd_c");
      #2;
      chk("w3_idle_ready", 32'(rdy[1]), 32'h1);
      chk("w3_idle_rdata", rd[1], 32'h0);

      @(negedge clk);
      req[1] = 1'b1;
      we[1] = 1'b1;
      addr[1] = 32'h8;
      wd[1] = 32'h1;
      #2;
      chk("abort_req_ready", 32'(rdy[1]), 32'h0);
      @(negedge clk);
      req[1] = 1'b0;
      we[1] = 1'b0;
      @(negedge clk);
      #2;
      chk("abort_idle_ready", 32'(rdy[1]), 32'h1);
      acc(1, 1'b0, 32'h8, 32'h0, 3, 32'hCAFE_0008, "abort_old");

      acc(1, 1'b1, 32'h14, 32'h0BAD_F00D, 3, 32'h0, "w3_wr");
      acc(1, 1'b0, 32'h14, 32'h0, 3, 32'h0BAD_F00D, "w3_rd_back");

      @(negedge clk);
      req[2] = 1'b1;
      we[2] = 1'b1;
      addr[2] = 32'h10;
      wd[2] = 32'hBBBB_BBBB;
      #2;
      chk("w2_req_ready", 32'(rdy[2]), 32'h0);
      @(negedge clk);
      #1;
      rstn[2] = 1'b0;
      #1;
      chk("midrst_ready", 32'(rdy[2]), 32'h1);
      chk("midrst_rdata", rd[2], 32'h0);
      @(negedge clk);
      req[2] = 1'b0;
      we[2] = 1'b0;
      @(negedge clk);
      rstn[2] = 1'b1;
      acc(2, 1'b0, 32'h10, 32'h0, 2, 32'hAAAA_0010, "midrst_nowrite");
      #2;
      chk("midrst_imem", id[2], 32'h2000_0001);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
